// File: rtl/barrel_shift_pipe_pkg.sv
// Shared types for the pipelined barrel shifter: the operation encoding and the
// per-stage register bundle, sized for the widest legal configuration.
package barrel_pkg;

   localparam int MAX_W   = 64;
   localparam int MAX_SHW = 6;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   typedef struct packed {
      logic [MAX_W-1:0]   data;
      logic [MAX_SHW-1:0] amt;
      shift_op_e          op;
      logic               valid;
   } stage_t;

   // All-ones in the low w bits; bits above the configured width stay zero.
   function automatic logic [MAX_W-1:0] width_mask(input int w);
      return {MAX_W{1'b1}} >> (MAX_W - w);
   endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready operand and result channels of the barrel shifter.
interface barrel_shift_pipe_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/barrel_shift_pipe_shift_stage.sv
// One shifter stage: conditionally shifts by 2^STAGE_IDX and registers the
// whole bundle when the pipeline advances.
module shift_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int STAGE_IDX = 0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en_i,
   input  stage_t stage_i,
   output stage_t stage_o
);

   localparam int              SH   = 1 << STAGE_IDX;
   localparam logic [MAX_W-1:0] MASK = width_mask(WIDTH);
   localparam logic [MAX_W-1:0] FILL = MASK & ~(MASK >> SH);

   stage_t           stage_d;
   stage_t           stage_q;
   logic [MAX_W-1:0] opnd;
   logic [MAX_W-1:0] shifted;

   always_comb begin
      opnd = stage_i.data & MASK;
      case (stage_i.op)
         OP_SLL:  shifted = (opnd << SH) & MASK;
         OP_SRL:  shifted = opnd >> SH;
         OP_SRA:  shifted = (opnd >> SH) | (opnd[WIDTH-1] ? FILL : '0);
         OP_ROR:  shifted = ((opnd >> SH) | (opnd << (WIDTH - SH))) & MASK;
         default: shifted = opnd;
      endcase

      stage_d = stage_i;
      stage_d.data = stage_i.amt[STAGE_IDX] ? shifted : opnd;
   end

   // ---- stage register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else if (en_i) begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR), one op per cycle,
// latency SHW; the whole pipe stalls as a unit when the output is blocked.
module barrel_shift_pipe
   import barrel_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   barrel_shift_pipe_if.slave   bus
);

   if (WIDTH < 8 || WIDTH > MAX_W || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("barrel_shift_pipe: WIDTH must be a power of two from 8 to 64");
   end

   stage_t in_stage;
   stage_t pipe [0:SHW-1];
   logic   advance;

   // No skid buffer: accepting input is exactly the condition for moving.
   assign advance     = !pipe[SHW-1].valid || bus.out_ready;
   assign bus.in_ready = advance;

   always_comb begin
      in_stage       = '0;
      in_stage.data  = MAX_W'(bus.in_data);
      in_stage.amt   = MAX_SHW'(bus.in_amt);
      in_stage.op    = shift_op_e'(bus.in_op);
      in_stage.valid = bus.in_valid;
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      if (k == 0) begin : g_first
         shift_stage #(
            .WIDTH     (WIDTH),
            .STAGE_IDX (k)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (advance),
            .stage_i (in_stage),
            .stage_o (pipe[k])
         );
      end else begin : g_rest
         shift_stage #(
            .WIDTH     (WIDTH),
            .STAGE_IDX (k)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (advance),
            .stage_i (pipe[k-1]),
            .stage_o (pipe[k])
         );
      end
   end

   // ---- output: last stage register ----
   assign bus.out_valid = pipe[SHW-1].valid;
   assign bus.out_data  = pipe[SHW-1].data[WIDTH-1:0];

   logic unused_last;
   assign unused_last = ^{pipe[SHW-1].data, pipe[SHW-1].amt, pipe[SHW-1].op};

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits; only powers of two from 8 to 64 are legal.
REQ-002 The block SHALL have derived parameter SHW, default $clog2(WIDTH) = 5, giving the shift-amount width and the pipeline depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: input operation is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts an input this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 The block SHALL have port in_amt, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have port in_op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: shifted result.

Function
REQ-013 The datapath SHALL have SHW registered stages; stage k shifts by 2^k when bit k of the captured amount is 1, and passes data through otherwise.
REQ-014 Each stage SHALL register data, valid, op and the remaining amount bits.
REQ-015 A transfer SHALL occur at the input when in_valid && in_ready, and at the output when out_valid && out_ready.
REQ-016 advance SHALL be !out_valid || out_ready; all stages move together when advance=1 and all hold when advance=0.
REQ-017 in_ready SHALL equal advance and be purely combinational; there is no skid buffer.
REQ-018 Latency SHALL be exactly SHW cycles from input transfer to out_valid with an unstalled output; throughput SHALL be 1 op/cycle.
REQ-019 When in_valid=0 on an advance, a bubble (valid=0) SHALL enter stage 0; bubbles propagate and do not stall.
REQ-020 SLL and SRL SHALL zero-fill; SRA SHALL fill with operand bit WIDTH-1; ROR SHALL rotate right with no fill.
REQ-021 Amount 0 SHALL return the operand unchanged for every op.
REQ-022 out_data SHALL be the last stage register and SHALL hold stable while out_valid=1 && out_ready=0.
REQ-023 Ordering SHALL be strict FIFO; no op is dropped or duplicated.

Reset
REQ-024 When rst_n=0 at a clock edge, every stage valid bit SHALL clear to 0 and out_valid SHALL be 0 from the next cycle; in-flight ops are discarded.
REQ-025 Data, amount and op registers SHALL reset to 0, so out_data=0 after reset.
REQ-026 During reset, in_ready SHALL evaluate to 1 (out_valid=0), but no input SHALL be captured while rst_n=0.

Structure
REQ-027 Package barrel_pkg SHALL hold enum shift_op_e (SLL, SRL, SRA, ROR) and a stage struct {data, amt, op, valid}.
REQ-028 One sub-module, shift_stage, SHALL be instantiated SHW times via generate, with parameter STAGE_IDX; it contains the 2:1 per-bit select plus the stage register with enable.
REQ-029 Implementation SHALL contain no latches and no multi-cycle paths.

Verification
REQ-030 SLL 0x0000_0001 by 31, out_ready=1 -> out_valid exactly 5 cycles later, out_data=0x8000_0000.
REQ-031 SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL of the same operand by 4 -> 0x0800_0000.
REQ-032 ROR 0x0000_00FF by 8 -> 0xFF00_0000; any op with amount 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
REQ-033 Back-to-back stream of 8 ops, then out_ready=0 for 3 cycles -> in_ready=0, out_data held, all 8 results in order, none lost.
REQ-034 rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result appears afterwards.
REQ-035 Randomised 10k ops with random out_ready, checked against a reference model -> zero mismatches.
